ifetch_unit: RTL and testbench

IFETCH_UNIT -- requirements
Module: ifetch_unit

---
 rtl/ifetch_unit.sv | 134 +++++++++++++
 tb/tb_ifetch_unit.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/ifetch_unit.sv
// Single-outstanding instruction fetch unit: drives the PC feedback path and a
// request/ack instruction memory port, with redirect draining and a fetch timeout.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MAX_WAIT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic [31:0] next_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  output logic        fetch_err
);
  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_HOLD, S_DRAIN, S_ERR} state_t;

  state_t        r_state, w_nstate;
  logic [CW-1:0] r_wait, w_wait_nx;
  logic [31:0]   r_drain_addr, r_instr, r_instr_pc;
  logic          r_instr_valid;
  logic          w_capture, w_clr_valid, w_latch_drain;
  logic          w_misaligned;

  assign w_misaligned = (pc_in[1:0] != 2'b00);

  always_comb begin
    w_nstate      = r_state;
    w_wait_nx     = r_wait;
    w_capture     = 1'b0;
    w_clr_valid   = 1'b0;
    w_latch_drain = 1'b0;
    next_pc       = pc_in;
    imem_req      = 1'b0;
    imem_addr     = 32'h0;
    case (r_state)
      S_IDLE: begin
        next_pc   = redirect ? redirect_pc : RESET_PC;
        w_wait_nx = '0;
        w_nstate  = S_FETCH;
      end
      S_FETCH: begin
        if (redirect) next_pc = redirect_pc;
        if (w_misaligned) begin
          w_nstate = S_ERR;
        end else begin
          imem_req  = 1'b1;
          imem_addr = pc_in;
          if (redirect) begin
            // An unacked request must still complete before the new target issues.
            w_wait_nx = '0;
            if (!imem_ack) begin
              w_latch_drain = 1'b1;
              w_nstate      = S_DRAIN;
            end
          end else if (imem_ack) begin
            next_pc   = pc_in + 32'd4;
            w_capture = 1'b1;
            w_nstate  = S_HOLD;
          end else if (r_wait == WAIT_LAST) begin
            w_nstate = S_ERR;
          end else begin
            w_wait_nx = r_wait + 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (redirect) next_pc = redirect_pc;
        if (redirect || !stall) begin
          w_clr_valid = 1'b1;
          w_wait_nx   = '0;
          w_nstate    = S_FETCH;
        end
      end
      S_DRAIN: begin
        imem_req  = 1'b1;
        imem_addr = r_drain_addr;
        if (imem_ack) begin
          w_wait_nx = '0;
          w_nstate  = S_FETCH;
        end else if (r_wait == WAIT_LAST) begin
          w_nstate = S_ERR;
        end else begin
          w_wait_nx = r_wait + 1'b1;
        end
      end
      S_ERR:   ;
      default: w_nstate = S_IDLE;
    endcase
    // Reset is asynchronous, so the combinational outputs must follow it too.
    if (!rst) begin
      next_pc   = RESET_PC;
      imem_req  = 1'b0;
      imem_addr = 32'h0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= S_IDLE;
      r_wait        <= '0;
      r_drain_addr  <= 32'h0;
      r_instr       <= 32'h0;
      r_instr_pc    <= 32'h0;
      r_instr_valid <= 1'b0;
    end else begin
      r_state <= w_nstate;
      r_wait  <= w_wait_nx;
      if (w_latch_drain) r_drain_addr <= pc_in;
      if (w_capture) begin
        r_instr       <= imem_rdata;
        r_instr_pc    <= pc_in;
        r_instr_valid <= 1'b1;
      end else if (w_clr_valid || w_nstate == S_ERR) begin
        r_instr_valid <= 1'b0;
      end
    end
  end

  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_instr_valid;
  assign fetch_err   = (r_state == S_ERR);
endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit: a PC register and a simple memory model close the loop.
module tb_ifetch_unit;
  logic        clk, rst;
  logic [31:0] pc_in, next_pc, imem_addr, imem_rdata, redirect_pc;
  logic [31:0] instr, instr_pc, pc_reg, ovr_val;
  logic        imem_req, imem_ack, stall, redirect, instr_valid, fetch_err;
  logic        auto_ack, man_ack, ovr_en;
  int          total, bad;

  ifetch_unit #(.RESET_PC(32'h0), .MAX_WAIT(15)) dut (
    .clk(clk), .rst(rst), .pc_in(pc_in), .next_pc(next_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .instr(instr), .instr_pc(instr_pc),
    .instr_valid(instr_valid), .fetch_err(fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_ff @(posedge clk or negedge rst)
    if (!rst) pc_reg <= 32'h0;
    else      pc_reg <= next_pc;

  assign pc_in      = ovr_en ? ovr_val : pc_reg;
  assign imem_ack   = auto_ack ? imem_req : man_ack;
  assign imem_rdata = imem_addr ^ 32'hA5A5_A5A5;

  typedef struct {
    logic        stall, redir;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr, npc;
    logic        vld;
    logic [31:0] ipc;
  } vec_t;
  vec_t vt [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    auto_ack = 1'b1; man_ack = 1'b0; ovr_en = 1'b0; ovr_val = 32'h0;
    step(); step();
    rst = 1'b1;
  endtask

  initial begin
    total = 0; bad = 0;
    // stall, redir, rpc, req, addr, npc, vld, ipc
    vt[0]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,  1'b0, 32'h0};
    vt[1]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h0,  32'h4,  1'b0, 32'h0};
    vt[2]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h4,  1'b1, 32'h0};
    vt[3]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  32'h8,  1'b0, 32'h0};
    vt[4]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h8,  1'b1, 32'h4};
    vt[5]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  32'hC,  1'b0, 32'h4};
    vt[6]  = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'hC,  1'b1, 32'h8};
    vt[7]  = '{1'b0, 1'b0, 32'h0,  1'b1, 32'hC,  32'h10, 1'b0, 32'h8};
    vt[8]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h10, 1'b1, 32'hC};
    vt[9]  = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h10, 1'b1, 32'hC};
    vt[10] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h10, 1'b1, 32'hC};
    vt[11] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h10, 1'b1, 32'hC};
    vt[12] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h10, 1'b1, 32'hC};
    vt[13] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h10, 1'b1, 32'hC};
    vt[14] = '{1'b0, 1'b1, 32'h40, 1'b1, 32'h10, 32'h40, 1'b0, 32'hC};
    vt[15] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h40, 32'h44, 1'b0, 32'hC};
    vt[16] = '{1'b1, 1'b1, 32'h80, 1'b0, 32'h0,  32'h80, 1'b1, 32'h40};
    vt[17] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h80, 32'h84, 1'b0, 32'h40};
    vt[18] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h84, 1'b1, 32'h80};

    // Reset state, with a redirect that must not leak onto next_pc
    rst = 1'b0; stall = 1'b0; redirect = 1'b1; redirect_pc = 32'h55;
    auto_ack = 1'b1; man_ack = 1'b0; ovr_en = 1'b0; ovr_val = 32'h0;
    step(); step(); #3;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_npc", next_pc, 32'h0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_ipc", instr_pc, 32'h0);
    chk("rst_vld", {31'h0, instr_valid}, 32'h0);
    chk("rst_err", {31'h0, fetch_err}, 32'h0);

    // Zero-wait stream, stall in HOLD, redirects in FETCH and HOLD
    do_reset();
    for (int i = 0; i < 19; i++) begin
      stall = vt[i].stall; redirect = vt[i].redir; redirect_pc = vt[i].rpc;
      #3;
      chk($sformatf("v%0d_req", i), {31'h0, imem_req}, {31'h0, vt[i].req});
      if (vt[i].req) chk($sformatf("v%0d_addr", i), imem_addr, vt[i].addr);
      chk($sformatf("v%0d_npc", i), next_pc, vt[i].npc);
      chk($sformatf("v%0d_vld", i), {31'h0, instr_valid}, {31'h0, vt[i].vld});
      chk($sformatf("v%0d_ipc", i), instr_pc, vt[i].ipc);
      if (vt[i].vld) chk($sformatf("v%0d_instr", i), instr, vt[i].ipc ^ 32'hA5A5_A5A5);
      chk($sformatf("v%0d_err", i), {31'h0, fetch_err}, 32'h0);
      step();
    end

    // PC wrap at the top of the address space
    do_reset();
    step();
    ovr_en = 1'b1; ovr_val = 32'hFFFF_FFFC; #3;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    chk("wrap_npc", next_pc, 32'h0);
    step(); ovr_en = 1'b0; #3;
    chk("wrap_ipc", instr_pc, 32'hFFFF_FFFC);
    chk("wrap_instr", instr, 32'h5A5A_5A59);
    chk("wrap_vld", {31'h0, instr_valid}, 32'h1);
    chk("wrap_pc", pc_in, 32'h0);

    // Redirect with the ack three cycles late: drain the old address first
    do_reset();
    auto_ack = 1'b0;
    step();
    redirect = 1'b1; redirect_pc = 32'h100; #3;
    chk("dr_req0", {31'h0, imem_req}, 32'h1);
    chk("dr_npc0", next_pc, 32'h100);
    step();
    redirect_pc = 32'h200; #3;
    chk("dr_addr1", imem_addr, 32'h0);
    chk("dr_npc1", next_pc, 32'h100);
    step();
    redirect = 1'b0; #3;
    chk("dr_req2", {31'h0, imem_req}, 32'h1);
    chk("dr_addr2", imem_addr, 32'h0);
    step();
    man_ack = 1'b1; #3;
    chk("dr_addr3", imem_addr, 32'h0);
    step();
    man_ack = 1'b0; #3;
    chk("dr_newaddr", imem_addr, 32'h100);
    chk("dr_vld", {31'h0, instr_valid}, 32'h0);
    man_ack = 1'b1;
    step();
    man_ack = 1'b0; #3;
    chk("dr_ipc", instr_pc, 32'h100);
    chk("dr_instr", instr, 32'hA5A5_A4A5);
    chk("dr_vld2", {31'h0, instr_valid}, 32'h1);

    // Reset mid-fetch drops the request at once; a stale ack in IDLE is ignored
    step(); #3;
    chk("rm_req", {31'h0, imem_req}, 32'h1);
    rst = 1'b0; #1;
    chk("rm_req0", {31'h0, imem_req}, 32'h0);
    chk("rm_npc", next_pc, 32'h0);
    chk("rm_vld", {31'h0, instr_valid}, 32'h0);
    man_ack = 1'b1;
    step();
    rst = 1'b1; #3;
    chk("rm_idle_vld", {31'h0, instr_valid}, 32'h0);
    step(); #3;
    chk("rm_idle_vld2", {31'h0, instr_valid}, 32'h0);
    man_ack = 1'b0;

    // Timeout after MAX_WAIT cycles without ack; ERR is sticky until reset
    do_reset();
    auto_ack = 1'b0;
    step();
    for (int i = 0; i < 14; i++) step();
    #3;
    chk("to_err14", {31'h0, fetch_err}, 32'h0);
    chk("to_req14", {31'h0, imem_req}, 32'h1);
    step(); #3;
    chk("to_err15", {31'h0, fetch_err}, 32'h1);
    chk("to_req15", {31'h0, imem_req}, 32'h0);
    man_ack = 1'b1; redirect = 1'b1; redirect_pc = 32'h300; #1;
    chk("to_npc", next_pc, 32'h0);
    step(); step(); #3;
    chk("to_sticky", {31'h0, fetch_err}, 32'h1);
    chk("to_vld", {31'h0, instr_valid}, 32'h0);
    chk("to_req_late", {31'h0, imem_req}, 32'h0);
    rst = 1'b0; #1;
    chk("to_clear", {31'h0, fetch_err}, 32'h0);

    // Misaligned PC on FETCH entry
    do_reset();
    ovr_en = 1'b1; ovr_val = 32'h102;
    step(); #3;
    chk("mis_req", {31'h0, imem_req}, 32'h0);
    chk("mis_err0", {31'h0, fetch_err}, 32'h0);
    step(); #3;
    chk("mis_err1", {31'h0, fetch_err}, 32'h1);
    chk("mis_req1", {31'h0, imem_req}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
